// File: rtl/spam_arbiter_pkg.sv
// Shared SPAM bus widths and arbiter state encodings.
package spam_defines;
  localparam int SPAM_DATA_HI = 31;
  localparam int SPAM_ADDR_HI = 15;
  localparam int SPAM_DID_HI  = 3;

  typedef enum logic [1:0] {
    SPAM_ARB_IDLE  = 2'd0,
    SPAM_ARB_ISSUE = 2'd1,
    SPAM_ARB_WAIT  = 2'd2,
    SPAM_ARB_DONE  = 2'd3
  } spam_arb_state_e;
endpackage

// File: rtl/spam_arbiter_if.sv
// Master-side request/completion bundle plus the shared SPAM bus.
interface spam_arbiter_if #(parameter int SPAM_MASTERS = 2);
  import spam_defines::*;

  logic [SPAM_MASTERS-1:0]                  m_req;
  logic [SPAM_MASTERS-1:0]                  m_r_nw;
  logic [SPAM_MASTERS*(SPAM_DID_HI+1)-1:0]  m_did;
  logic [SPAM_MASTERS*(SPAM_ADDR_HI+1)-1:0] m_addr;
  logic [SPAM_MASTERS*(SPAM_DATA_HI+1)-1:0] m_wdata;
  logic [SPAM_MASTERS-1:0]                  m_done;
  logic                                     m_err;
  logic [SPAM_DATA_HI:0]                    m_rdata;
  logic                                     spamo_valid;
  logic                                     spamo_r_nw;
  logic [SPAM_DID_HI:0]                     spamo_did;
  logic [SPAM_ADDR_HI:0]                    spamo_addr;
  logic [SPAM_DATA_HI:0]                    spamo_data;
  logic                                     spami_busy_b;
  logic [SPAM_DATA_HI:0]                    spami_data;

  // Arbiter side.
  modport slave (
    input  m_req, m_r_nw, m_did, m_addr, m_wdata, spami_busy_b, spami_data,
    output m_done, m_err, m_rdata,
    output spamo_valid, spamo_r_nw, spamo_did, spamo_addr, spamo_data
  );

  // Requester/bus-model side.
  modport master (
    output m_req, m_r_nw, m_did, m_addr, m_wdata, spami_busy_b, spami_data,
    input  m_done, m_err, m_rdata,
    input  spamo_valid, spamo_r_nw, spamo_did, spamo_addr, spamo_data
  );
endinterface

// File: rtl/spam_arbiter_rr_pick.sv
// Round-robin first-set finder: lowest requester at or after ptr, wrapping.
module spam_rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt,
  output logic          any
);
  int idx;

  // Scan from the farthest offset down so the nearest hit is assigned last.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (req[PW'(idx)]) begin
        gnt = PW'(idx);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spam_arbiter.sv
// Serializes SPAM_MASTERS requesters onto the single SPAM bus, one command at a time.
module spam_arbiter import spam_defines::*; #(
  parameter int                    SPAM_MASTERS   = 2,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [SPAM_DATA_HI:0] ERR_DATA       = 32'hDEADDEAD
) (
  input logic          clk,
  input logic          rst_b,
  spam_arbiter_if.slave bus
);
  localparam int N  = SPAM_MASTERS;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW = SPAM_DATA_HI + 1;
  localparam int AW = SPAM_ADDR_HI + 1;
  localparam int IW = SPAM_DID_HI + 1;

  spam_arb_state_e state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d, gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d, r_nw_q, r_nw_d, m_err_q, m_err_d;
  logic [IW-1:0]   did_q, did_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d, m_rdata_q, m_rdata_d;
  logic [N-1:0]    m_done_q, m_done_d;
  logic [PW-1:0]   pick_gnt;
  logic            pick_any;

  spam_rr_pick #(.N(N), .PW(PW)) u_pick (
    .req (bus.m_req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    r_nw_d    = r_nw_q;
    did_d     = did_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    m_err_d   = m_err_q;
    m_rdata_d = m_rdata_q;
    m_done_d  = '0;
    unique case (state_q)
      SPAM_ARB_IDLE: if (pick_any) begin
        // Command is snapshotted here so the master may change its inputs freely.
        gnt_d   = pick_gnt;
        r_nw_d  = bus.m_r_nw[pick_gnt];
        did_d   = bus.m_did[int'(pick_gnt)*IW +: IW];
        addr_d  = bus.m_addr[int'(pick_gnt)*AW +: AW];
        wdata_d = bus.m_wdata[int'(pick_gnt)*DW +: DW];
        valid_d = 1'b1;
        state_d = SPAM_ARB_ISSUE;
      end
      SPAM_ARB_ISSUE: begin
        cnt_d   = '0;
        state_d = SPAM_ARB_WAIT;
      end
      SPAM_ARB_WAIT: begin
        // A real completion beats a simultaneous timeout.
        if (bus.spami_busy_b) begin
          m_rdata_d = bus.spami_data;
          m_err_d   = 1'b0;
          state_d   = SPAM_ARB_DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          m_rdata_d = ERR_DATA;
          m_err_d   = 1'b1;
          state_d   = SPAM_ARB_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (state_d == SPAM_ARB_DONE)
          for (int i = 0; i < N; i++) m_done_d[i] = (int'(gnt_q) == i);
      end
      SPAM_ARB_DONE: begin
        rr_ptr_d = (int'(gnt_q) == N - 1) ? '0 : gnt_q + PW'(1);
        state_d  = SPAM_ARB_IDLE;
      end
      default: state_d = SPAM_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= SPAM_ARB_IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      r_nw_q    <= 1'b0;
      did_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      m_err_q   <= 1'b0;
      m_rdata_q <= '0;
      m_done_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      r_nw_q    <= r_nw_d;
      did_q     <= did_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      m_err_q   <= m_err_d;
      m_rdata_q <= m_rdata_d;
      m_done_q  <= m_done_d;
    end
  end

  assign bus.spamo_valid = valid_q;
  assign bus.spamo_r_nw  = r_nw_q;
  assign bus.spamo_did   = did_q;
  assign bus.spamo_addr  = addr_q;
  assign bus.spamo_data  = wdata_q;
  assign bus.m_done      = m_done_q;
  assign bus.m_err       = m_err_q;
  assign bus.m_rdata     = m_rdata_q;
endmodule

// File: tb/tb_spam_arbiter.sv
// Scoreboard bench for spam_arbiter: 2 masters, 8-cycle timeout, autonomous slave model.
module tb_spam_arbiter;
  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  spam_arbiter_if #(.SPAM_MASTERS(2)) bus ();

  spam_arbiter #(.SPAM_MASTERS(2), .TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEADDEAD)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  typedef struct {
    int          m;
    logic        rnw;
    logic [3:0]  did;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rd;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          slave_dly = 0;
  logic [31:0] slave_data = '0;
  logic        kick = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_cmd(int m, logic rnw, logic [3:0] did, logic [15:0] addr, logic [31:0] wd);
    bus.m_r_nw[m]          = rnw;
    bus.m_did[m*4 +: 4]    = did;
    bus.m_addr[m*16 +: 16] = addr;
    bus.m_wdata[m*32 +: 32] = wd;
  endtask

  task automatic push(int m, logic rnw, logic [3:0] did, logic [15:0] addr, logic [31:0] wd,
                      logic err, logic [31:0] rd, int lat);
    exp_t e;
    e.m = m; e.rnw = rnw; e.did = did; e.addr = addr; e.wdata = wd;
    e.err = err; e.rd = rd; e.lat = lat;
    sb.push_back(e);
  endtask

  // One transaction from master m; dly = WAIT cycles before the slave completes (-1 = never).
  task automatic run(int m, logic rnw, logic [3:0] did, logic [15:0] addr, logic [31:0] wd,
                     int dly, logic [31:0] sd, logic eerr, logic [31:0] erd, int lat, logic chg);
    logic seen;
    push(m, rnw, did, addr, wd, eerr, erd, lat);
    slave_dly  = dly;
    slave_data = sd;
    set_cmd(m, rnw, did, addr, wd);
    bus.m_req[m] = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (chg && k == 3) bus.m_addr[m*16 +: 16] = addr + 16'h10;
      if (bus.m_done[m]) begin
        seen = 1'b1;
        bus.m_req = '0;
        break;
      end
    end
    chk("done_seen", {31'b0, seen}, 32'd1);
  endtask

  // Slave model: responds slave_dly WAIT cycles after each command strobe.
  initial begin : slave
    bit arm;
    int cnt;
    arm = 0; cnt = 0;
    bus.spami_busy_b = 1'b0;
    bus.spami_data   = '0;
    forever begin
      @(negedge clk);
      bus.spami_busy_b = 1'b0;
      bus.spami_data   = '0;
      if (!rst_b) arm = 0;
      else if (kick) begin
        bus.spami_busy_b = 1'b1;
        bus.spami_data   = slave_data;
        kick = 1'b0;
      end else if (bus.spamo_valid) begin
        if (slave_dly >= 0) begin arm = 1; cnt = slave_dly; end
      end else if (arm) begin
        if (cnt == 0) begin
          bus.spami_busy_b = 1'b1;
          bus.spami_data   = slave_data;
          arm = 0;
        end else cnt--;
      end
    end
  end

  // Monitor: strobe count, command stability, completion against the scoreboard.
  initial begin : monitor
    exp_t e;
    int vcnt, vcyc;
    vcnt = 0; vcyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_b) begin vcnt = 0; continue; end
      if (bus.spamo_valid) begin vcnt++; vcyc = cyc; end
      if (sb.size() > 0 && vcnt > 0) begin
        chk("spamo_addr", {16'b0, bus.spamo_addr}, {16'b0, sb[0].addr});
        chk("spamo_did",  {28'b0, bus.spamo_did},  {28'b0, sb[0].did});
        chk("spamo_r_nw", {31'b0, bus.spamo_r_nw}, {31'b0, sb[0].rnw});
        chk("spamo_data", bus.spamo_data, sb[0].wdata);
      end
      if (bus.m_done != 2'b00) begin
        if (sb.size() == 0) chk("spurious_done", {30'b0, bus.m_done}, 32'd0);
        else begin
          e = sb.pop_front();
          chk("m_done",    {30'b0, bus.m_done}, 32'd1 << e.m);
          chk("m_err",     {31'b0, bus.m_err},  {31'b0, e.err});
          chk("m_rdata",   bus.m_rdata, e.rd);
          chk("latency",   32'(cyc - vcyc), 32'(e.lat));
          chk("valid_cnt", 32'(vcnt), 32'd1);
          vcnt = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n, t;
    rst_b     = 1'b0;
    bus.m_req = '0; bus.m_r_nw = '0; bus.m_did = '0; bus.m_addr = '0; bus.m_wdata = '0;

    // Both masters request while still in reset.
    set_cmd(0, 1'b1, 4'h1, 16'h0100, 32'h0);
    set_cmd(1, 1'b1, 4'h2, 16'h0200, 32'h0);
    bus.m_req = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, bus.spamo_valid}, 32'd0);
    chk("rst_addr",  {16'b0, bus.spamo_addr},  32'd0);
    chk("rst_data",  bus.spamo_data,           32'd0);
    chk("rst_done",  {30'b0, bus.m_done},      32'd0);
    chk("rst_err",   {31'b0, bus.m_err},       32'd0);
    chk("rst_rdata", bus.m_rdata,              32'd0);

    // Contention: round robin 0,1,0,1.
    slave_dly = 0; slave_data = 32'h5555_0000;
    for (int i = 0; i < 4; i++)
      push(i % 2, 1'b1, (i % 2) ? 4'h2 : 4'h1, (i % 2) ? 16'h0200 : 16'h0100, 32'h0,
           1'b0, 32'h5555_0000, 2);
    rst_b = 1'b1;
    n = 0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clk);
      if (bus.m_done != 2'b00) n++;
      if (n == 4) bus.m_req = '0;
    end
    chk("contention_dones", 32'(n), 32'd4);
    @(negedge clk);

    // Single read, write (data captured anyway), timeout, recovery, coincidence, stability.
    run(0, 1'b1, 4'h2, 16'h0010, 32'h0,        2, 32'h1234_5678, 1'b0, 32'h1234_5678, 4, 1'b0);
    run(1, 1'b0, 4'h5, 16'h0044, 32'hCAFE_F00D, 1, 32'h0000_BEEF, 1'b0, 32'h0000_BEEF, 3, 1'b0);
    run(0, 1'b1, 4'h7, 16'h0080, 32'h0,       -1, 32'h0,         1'b1, 32'hDEAD_DEAD, 9, 1'b0);
    run(1, 1'b1, 4'h3, 16'h0090, 32'h0,        0, 32'h1111_2222, 1'b0, 32'h1111_2222, 2, 1'b0);
    run(0, 1'b1, 4'h4, 16'h00A0, 32'h0,        7, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 9, 1'b0);
    run(1, 1'b1, 4'h1, 16'h0020, 32'h0,        3, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 5, 1'b1);
    // Leaves the pointer at master 1 before the reset test.
    run(0, 1'b1, 4'h6, 16'h00B0, 32'h0,        0, 32'h3333_4444, 1'b0, 32'h3333_4444, 2, 1'b0);

    // Reset mid-WAIT from master 0 (no slave response).
    push(0, 1'b1, 4'h8, 16'h00C0, 32'h0, 1'b0, 32'h0, 2);
    slave_dly = -1;
    set_cmd(0, 1'b1, 4'h8, 16'h00C0, 32'h0);
    bus.m_req[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    sb.delete();
    bus.m_req = '0;
    chk("mid_rst_valid", {31'b0, bus.spamo_valid}, 32'd0);
    chk("mid_rst_addr",  {16'b0, bus.spamo_addr},  32'd0);
    chk("mid_rst_done",  {30'b0, bus.m_done},      32'd0);
    chk("mid_rst_err",   {31'b0, bus.m_err},       32'd0);
    chk("mid_rst_rdata", bus.m_rdata,              32'd0);
    rst_b = 1'b1;
    slave_data = 32'hFFFF_0000;
    kick = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_done",  {30'b0, bus.m_done},      32'd0);
      chk("post_rst_valid", {31'b0, bus.spamo_valid}, 32'd0);
    end

    // Pointer must be back at 0: master 0 wins over master 1.
    slave_dly = 0; slave_data = 32'h7777_8888;
    set_cmd(0, 1'b1, 4'h9, 16'h00D0, 32'h0);
    set_cmd(1, 1'b1, 4'hA, 16'h00E0, 32'h0);
    push(0, 1'b1, 4'h9, 16'h00D0, 32'h0, 1'b0, 32'h7777_8888, 2);
    bus.m_req = 2'b11;
    t = 0; n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.m_done != 2'b00) begin t = k; n = 1; bus.m_req = '0; break; end
    end
    chk("fresh_done", 32'(n), 32'd1);
    chk("req_to_done", 32'(t), 32'd3);
    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spam_arbiter.md
Name: spam_arbiter

Overview:
- Shares the single SPAM peripheral bus (spamo_* out, spami_* in) between SPAM_MASTERS requesters, e.g. the core plus a debug/DMA master.
- Serializes transactions with round-robin priority, drives exactly one spamo_valid pulse per transaction, and waits for slave completion.
- Returns read data and a done pulse to the granted master only.
- A timeout counter guarantees forward progress when no slave decodes the address.

Parameters:
- SPAM_MASTERS, 2, number of requesters (1..8).
- TIMEOUT_CYCLES, 255, WAIT cycles before a forced error completion (1..65535).
- ERR_DATA, 32'hDEADDEAD, read data returned on timeout.

Ports:
- clk  input  1  system clock
- rst_b  input  1  asynchronous active-low reset
- m_req  input  SPAM_MASTERS  per-master request, level; held until that master's m_done
- m_r_nw  input  SPAM_MASTERS  1 = read, 0 = write
- m_did  input  SPAM_MASTERS*(SPAM_DID_HI+1)  device id, master i at slice i
- m_addr  input  SPAM_MASTERS*(SPAM_ADDR_HI+1)  address, flattened
- m_wdata  input  SPAM_MASTERS*(SPAM_DATA_HI+1)  write data, flattened
- m_done  output  SPAM_MASTERS  one-cycle completion pulse, one-hot or zero
- m_err  output  1  valid with m_done; 1 = timeout completion
- m_rdata  output  SPAM_DATA_HI+1  read data, valid with m_done
- spamo_valid  output  1  one-cycle command strobe
- spamo_r_nw  output  1  command direction
- spamo_did  output  SPAM_DID_HI+1  command device id
- spamo_addr  output  SPAM_ADDR_HI+1  command address
- spamo_data  output  SPAM_DATA_HI+1  command write data
- spami_busy_b  input  1  OR of slave completions; 1 = transaction complete this cycle
- spami_data  input  SPAM_DATA_HI+1  OR of slave read data, valid when spami_busy_b=1

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, spamo_*=0, m_done=0, m_err=0, m_rdata=0, timeout counter=0.
- IDLE:
  - If any m_req is set, choose the first requester at or after rr_ptr (wrapping modulo SPAM_MASTERS).
  - Latch grant, r_nw, did, addr and wdata into registers; go to ISSUE.
  - The latched command is stable even if the master changes its inputs.
- ISSUE (1 cycle):
  - spamo_valid=1; spamo_* show the latched command.
  - Clear the counter; go to WAIT.
- WAIT:
  - spamo_valid=0; spamo_* keep their values. spami_busy_b is ignored outside WAIT.
  - If spami_busy_b=1: capture spami_data into m_rdata (captured for writes too; masters ignore it); m_err=0; go to DONE.
  - Else if counter==TIMEOUT_CYCLES-1: m_rdata=ERR_DATA, m_err=1; go to DONE.
  - Else counter+1.
  - If completion and timeout coincide, completion wins (m_err=0).
- DONE (1 cycle):
  - m_done[grant]=1; rr_ptr=(grant+1) wrap SPAM_MASTERS; go to IDLE.
  - m_rdata and m_err hold until the next DONE.
- Latency:
  - Minimum from m_req rising in IDLE to m_done is 4 cycles: IDLE sample, ISSUE, WAIT with completion, DONE.
  - Back-to-back transactions start every 4 cycles.
- The master must drop m_req in the cycle after m_done. An m_req still high when IDLE is next sampled counts as a new request.
- Dropping m_req mid-transaction has no effect; the transaction still completes and pulses m_done.
- A single-master build (SPAM_MASTERS=1) has a constant rr_ptr of 0.
- Counter width: clog2(TIMEOUT_CYCLES+1); no wrap is possible.
- Asynchronous reset mid-transaction returns to IDLE with all outputs 0. Any in-flight slave completion after reset is ignored because the state is not WAIT.

Decomposition:
- Shared package (spam_defines): SPAM_DATA_HI, SPAM_ADDR_HI, SPAM_DID_HI, and state encodings SPAM_ARB_IDLE/ISSUE/WAIT/DONE.
- One sub-module: spam_rr_pick, a combinational round-robin first-set finder over (req, ptr) producing a grant index and any_req. It is reusable for later SPAM fan-in.

Test Plan:
- Single read: master0 reads did=2, addr=0x10; slave responds 3 cycles after spamo_valid with spami_data=0x12345678 -> exactly one spamo_valid pulse, m_done=2'b01, m_rdata=0x12345678, m_err=0.
- Contention: m_req=2'b11 held from reset -> grants in order 0,1,0,1; each m_done one-hot; spamo_addr matches the granted master every time.
- Timeout: TIMEOUT_CYCLES=8, no slave response -> m_done exactly 8 cycles after the WAIT entry cycle, m_err=1, m_rdata=0xDEADDEAD; next request proceeds normally.
- Coincidence: spami_busy_b=1 on the final timeout cycle with data 0xA5A5A5A5 -> m_err=0, m_rdata=0xA5A5A5A5.
- Input stability: master1 changes m_addr from 0x20 to 0x30 during WAIT -> spamo_addr stays 0x20 until DONE.
- Reset mid-WAIT: assert rst_b=0 during WAIT, then release; assert spami_busy_b=1 after release -> no m_done, all outputs 0, rr_ptr=0; a fresh request then completes in 4 cycles.
